// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: instruction width, halt opcode, FSM encoding, IF/ID payload.
// Pure types and helpers, no logic.
package inst_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic [31:0]        pc_plus4;
    } if_id_t;

    // Sequential fetch step; wraps silently at the top of the address space.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory port: fetch unit is master, memory is slave.
// Read data is combinational from the address.
interface inst_fetch_if;

    logic [31:0] imem_address;
    logic        imem_memWrite;
    logic [31:0] imem_Data_in;
    logic [31:0] imem_Data_out;

    modport master (
        output imem_address,
        output imem_memWrite,
        output imem_Data_in,
        input  imem_Data_out
    );

    modport slave (
        input  imem_address,
        input  imem_memWrite,
        input  imem_Data_in,
        output imem_Data_out
    );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register; one-cycle capture, hold freezes contents.
// Clear drops only the valid bit and overrides hold.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   clear,
    input  logic   capture,
    input  if_id_t load_dat,
    output if_id_t q
);

    if_id_t q_q;
    if_id_t q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d.valid = 1'b0;
        end else if (capture && !hold) begin
            q_d = load_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: IDLE loader passthrough, RUN sequential fetch into IF/ID, HALT on halt opcode.
// Read-to-latch latency one cycle; stall freezes PC and IF/ID, redirect flushes and wins over stall.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_we,
    input  logic [31:0]        load_addr,
    input  logic [31:0]        load_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    inst_fetch_if.master       imem,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               halted
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         halted_q, halted_d;

    logic   fetch_fire;
    logic   is_halt;
    logic   ifid_hold;
    logic   ifid_clear;
    logic   ifid_capture;
    if_id_t ifid_load;
    if_id_t ifid_q;

    assign fetch_fire = (state_q == ST_RUN) && !stall && !redirect;
    assign is_halt    = (imem.imem_Data_out[INSTR_W-1 -: 6] == HALT_OPCODE);

    // State, PC and halted flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (fetch_fire && is_halt) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // PC update; only RUN moves it, and redirect targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (state_q == ST_RUN) begin
            if (redirect) begin
                pc_d = redirect_pc & ~32'h0000_0003;
            end else if (!stall) begin
                pc_d = pc_inc(pc_q);
            end
        end
    end

    // Registered so halted has no combinational path from any input.
    assign halted_d = (state_d == ST_HALT);

    // Output logic: memory port mux and IF/ID controls
    always_comb begin
        imem.imem_address  = pc_q;
        imem.imem_memWrite = 1'b0;
        imem.imem_Data_in  = 32'h0000_0000;
        ifid_hold          = stall;
        ifid_clear         = 1'b0;
        ifid_capture       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                imem.imem_address  = load_addr;
                imem.imem_memWrite = load_we && !reset;
                imem.imem_Data_in  = load_data;
            end
            ST_RUN: begin
                ifid_clear   = redirect;
                ifid_capture = !redirect;
            end
            ST_HALT: begin
                ifid_clear = !stall;
            end
            default: begin
                imem.imem_memWrite = 1'b0;
            end
        endcase
    end

    assign ifid_load.valid    = 1'b1;
    assign ifid_load.instr    = imem.imem_Data_out;
    assign ifid_load.pc       = pc_q;
    assign ifid_load.pc_plus4 = pc_inc(pc_q);

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .hold     (ifid_hold),
        .clear    (ifid_clear),
        .capture  (ifid_capture),
        .load_dat (ifid_load),
        .q        (ifid_q)
    );

    assign if_valid    = ifid_q.valid;
    assign if_instr    = ifid_q.instr;
    assign if_pc       = ifid_q.pc;
    assign if_pc_plus4 = ifid_q.pc_plus4;
    assign halted      = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: loader, sequential fetch, stall, redirect, halt, reset, PC wrap.
// A second instance with RESET_PC at the top of memory checks the wrap.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;

    logic        d2_valid;
    logic [31:0] d2_instr;
    logic [31:0] d2_pc;
    logic [31:0] d2_pc_plus4;
    logic        d2_halted;

    int n_vec;
    int n_err;

    inst_fetch_if imem ();
    inst_fetch_if imem2 ();

    logic [31:0] mem [0:63];

    assign imem.imem_Data_out  = mem[imem.imem_address[7:2]];
    assign imem2.imem_Data_out = 32'h0000_0013;

    always @(posedge clk) begin
        if (imem.imem_memWrite) mem[imem.imem_address[7:2]] <= imem.imem_Data_in;
    end

    inst_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .halted      (halted)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem2),
        .if_valid    (d2_valid),
        .if_instr    (d2_instr),
        .if_pc       (d2_pc),
        .if_pc_plus4 (d2_pc_plus4),
        .halted      (d2_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic go);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        start     = go;
        tick();
        load_we   = 1'b0;
        start     = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  {31'b0, if_valid}, 32'h0);
        chk({tag, "_instr"},  if_instr, 32'h0);
        chk({tag, "_pc"},     if_pc, 32'h0);
        chk({tag, "_pc4"},    if_pc_plus4, 32'h0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
        chk({tag, "_memwe"},  {31'b0, imem.imem_memWrite}, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; start = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Power-on reset with the loader strobe already high
        #2;
        reset = 1'b1; load_we = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
        #1;
        chk_reset_vals("por");
        tick();
        chk_reset_vals("por_hold");
        reset = 1'b0; load_we = 1'b0;
        tick();

        // IDLE loader passthrough
        load_we = 1'b1; load_addr = 32'h4; load_data = 32'h1234_5678;
        #1;
        chk("idle_memwe", {31'b0, imem.imem_memWrite}, 32'h1);
        chk("idle_addr",  imem.imem_address, 32'h4);
        chk("idle_wdat",  imem.imem_Data_in, 32'h1234_5678);
        tick();
        load_we = 1'b0;
        load(32'h8,  32'h0000_0013, 1'b0);
        load(32'h40, 32'h1111_1111, 1'b0);
        chk("idle_valid", {31'b0, if_valid}, 32'h0);
        // Last word written in the same cycle as start
        load(32'h0,  32'h0000_ABCD, 1'b1);
        chk("run0_valid", {31'b0, if_valid}, 32'h0);
        chk("run0_addr",  imem.imem_address, 32'h0);
        chk("run0_memwe", {31'b0, imem.imem_memWrite}, 32'h0);

        tick();
        chk("f1_valid", {31'b0, if_valid}, 32'h1);
        chk("f1_instr", if_instr, 32'h0000_ABCD);
        chk("f1_pc",    if_pc, 32'h0);
        chk("f1_pc4",   if_pc_plus4, 32'h4);
        chk("wrap1_pc",  d2_pc, 32'hFFFF_FFFC);
        chk("wrap1_pc4", d2_pc_plus4, 32'h0);
        tick();
        chk("f2_instr", if_instr, 32'h1234_5678);
        chk("f2_pc",    if_pc, 32'h4);
        chk("wrap2_pc", d2_pc, 32'h0);

        // Three stall cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    if_pc, 32'h4);
            chk("stall_instr", if_instr, 32'h1234_5678);
            chk("stall_addr",  imem.imem_address, 32'h8);
        end
        stall = 1'b0;
        tick();
        chk("resume_pc",    if_pc, 32'h8);
        chk("resume_instr", if_instr, 32'h0000_0013);
        chk("resume_addr",  imem.imem_address, 32'hC);

        // Redirect to an unaligned target together with stall
        redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        tick();
        chk("redir_valid", {31'b0, if_valid}, 32'h0);
        chk("redir_addr",  imem.imem_address, 32'h40);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk("redir_f_valid", {31'b0, if_valid}, 32'h1);
        chk("redir_f_pc",    if_pc, 32'h40);
        chk("redir_f_instr", if_instr, 32'h1111_1111);
        chk("redir_f_pc4",   if_pc_plus4, 32'h44);

        // Reset mid-RUN with the loader strobe high
        reset = 1'b1; load_we = 1'b1; load_addr = 32'h20; load_data = 32'hCAFE_F00D;
        #1;
        chk_reset_vals("mid");
        chk("mid_addr", imem.imem_address, 32'h20);
        tick();
        reset = 1'b0; load_we = 1'b0;
        tick();

        // Halt instruction at 0x8
        load(32'h8, 32'hFC00_0000, 1'b1);
        tick();
        chk("h1_pc", if_pc, 32'h0);
        tick();
        chk("h2_pc",     if_pc, 32'h4);
        chk("h2_halted", {31'b0, halted}, 32'h0);
        stall = 1'b0;
        tick();
        chk("h3_halted", {31'b0, halted}, 32'h1);
        chk("h3_valid",  {31'b0, if_valid}, 32'h1);
        chk("h3_instr",  if_instr, 32'hFC00_0000);
        chk("h3_pc",     if_pc, 32'h8);
        chk("h3_addr",   imem.imem_address, 32'hC);

        // Redirect and start are ignored in HALT; stall holds IF/ID
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; start = 1'b1;
        tick();
        chk("hs_valid", {31'b0, if_valid}, 32'h1);
        chk("hs_pc",    if_pc, 32'h8);
        chk("hs_addr",  imem.imem_address, 32'hC);
        stall = 1'b0;
        tick();
        chk("hc_valid",  {31'b0, if_valid}, 32'h0);
        chk("hc_addr",   imem.imem_address, 32'hC);
        chk("hc_halted", {31'b0, halted}, 32'h1);
        redirect = 1'b0; start = 1'b0;
        tick();
        chk("hz_halted", {31'b0, halted}, 32'h1);
        chk("hz_pc",     if_pc, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, byte address loaded into PC by reset.
REQ-002 Parameter HALT_OPCODE, 6'h3F, opcode in instr[31:26] that stops fetch.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; IDLE -> RUN.
REQ-006 load_we  input  1  loader write strobe, honoured only in IDLE.
REQ-007 load_addr  input  32  loader byte address.
REQ-008 load_data  input  32  loader write data.
REQ-009 stall  input  1  downstream hold; freezes PC and IF/ID register.
REQ-010 redirect  input  1  branch/jump taken; flushes and reloads PC.
REQ-011 redirect_pc  input  32  redirect target byte address.
REQ-012 imem_address  output  32  to instruction memory address.
REQ-013 imem_memWrite  output  1  to instruction memory write enable.
REQ-014 imem_Data_in  output  32  to instruction memory write data.
REQ-015 imem_Data_out  input  32  combinational read data from instruction memory.
REQ-016 if_valid  output  1  IF/ID register holds a real instruction.
REQ-017 if_instr  output  32  latched instruction.
REQ-018 if_pc  output  32  address of if_instr.
REQ-019 if_pc_plus4  output  32  if_pc + 4, mod 2^32.
REQ-020 halted  output  1  high while in HALT.

Function
REQ-021 State machine states: IDLE, RUN, HALT; reset enters IDLE.
REQ-022 IDLE: imem_address = load_addr, imem_memWrite = load_we, imem_Data_in = load_data; PC holds; if_valid = 0.
REQ-023 IDLE -> RUN on start; a load_we in the same cycle as start still writes.
REQ-024 RUN and HALT: imem_address = PC, imem_memWrite = 0, imem_Data_in = 0; load_* ignored.
REQ-025 RUN, no stall, no redirect: IF/ID <= {1, imem_Data_out, PC, PC+4}; PC <= PC+4; read-to-latch latency one cycle.
REQ-026 RUN, stall, no redirect: PC and all IF/ID outputs hold their values.
REQ-027 RUN, redirect (with or without stall): PC <= {redirect_pc[31:2], 2'b00}; if_valid <= 0; redirect has priority over stall.
REQ-028 PC increment wraps 32'hFFFFFFFC -> 32'h00000000 with no flag.
REQ-029 RUN -> HALT when an instruction with instr[31:26] == HALT_OPCODE is latched under REQ-025; the halt instruction remains in IF/ID with if_valid = 1.
REQ-030 HALT: PC frozen; IF/ID holds while stall = 1; if_valid <= 0 on the first non-stall cycle; redirect and start ignored; only reset exits.
REQ-031 halted = (state == HALT), registered, no combinational input path.

Reset
REQ-032 Reset, asserted at any time including mid-fetch or mid-load, immediately forces: state = IDLE, PC = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, if_pc_plus4 = 0, halted = 0.
REQ-033 During reset, imem_memWrite = 0 regardless of load_we.

Structure
REQ-034 Package holds the state enum encoding, the HALT_OPCODE default, and the instruction width constant 32, shared with decode.
REQ-035 One sub-module, if_id_reg, holds the IF/ID register with hold and clear controls; PC logic and the FSM remain in inst_fetch.

Verification
REQ-036 Load 32'h12345678 at 0x4 and 32'h0000ABCD at 0x0 in IDLE, then start -> cycles 1 and 2 give if_pc 0x0 then 0x4, if_instr 32'h0000ABCD then 32'h12345678.
REQ-037 Hold stall for 3 cycles in RUN -> if_pc, if_instr and PC stay constant; fetch resumes at the next sequential address.
REQ-038 Assert redirect with redirect_pc = 32'h00000043 together with stall -> next cycle if_valid = 0 and PC = 32'h00000040; the following cycle if_pc = 0x40.
REQ-039 Store instruction 32'hFC000000 at 0x8 -> halted rises the cycle it is latched; later redirect has no effect; if_valid clears after stall drops.
REQ-040 Assert reset mid-RUN and mid-load with load_we = 1 -> all outputs at their REQ-032 values at once and imem_memWrite = 0.
REQ-041 Start with RESET_PC = 32'hFFFFFFFC -> second fetched if_pc = 32'h00000000.
